// File: rtl/pump_scheduler_if.sv
// Command bus between the UI/command decoder (master) and pump_scheduler (slave).
interface pump_scheduler_if #(
   parameter int NUM_PUMPS = 3,
   parameter int SEC_W     = 16
);
   localparam int CH_W = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1;

   logic             cmd_valid;
   logic [1:0]       cmd_op;
   logic [CH_W-1:0]  cmd_chan;
   logic [SEC_W-1:0] cmd_period;
   logic [SEC_W-1:0] cmd_on_time;
   logic             cmd_ack;
   logic             cmd_err;

   modport master (
      output cmd_valid, cmd_op, cmd_chan, cmd_period, cmd_on_time,
      input  cmd_ack, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_chan, cmd_period, cmd_on_time,
      output cmd_ack, cmd_err
   );
endinterface

// File: rtl/pump_scheduler.sv
// N-channel pump scheduler: per-channel period/on-time schedule, manual one-shots and
// optional single-pump exclusion, all timed by one shared seconds prescaler.
module pump_scheduler #(
   parameter int NUM_PUMPS  = 3,
   parameter int CLOCK_FREQ = 1_000_000,
   parameter int SEC_W      = 16,
   parameter int EXCLUSIVE  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   pump_scheduler_if.slave      cmd,
   output logic [NUM_PUMPS-1:0] pump_out,
   output logic [NUM_PUMPS-1:0] active,
   output logic                 sec_tick
);
   localparam int CH_W = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1;
   localparam int PS_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLOCK_FREQ - 1);

   localparam logic [1:0] OP_START    = 2'd0;
   localparam logic [1:0] OP_STOP     = 2'd1;
   localparam logic [1:0] OP_MANUAL   = 2'd2;
   localparam logic [1:0] OP_STOP_ALL = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      PEND  = 2'd2,
      PULSE = 2'd3
   } state_t;

   logic [PS_W-1:0]      presc;

   state_t               state       [NUM_PUMPS];
   state_t               state_nx    [NUM_PUMPS];
   logic [SEC_W-1:0]     wait_cnt    [NUM_PUMPS];
   logic [SEC_W-1:0]     wait_cnt_nx [NUM_PUMPS];
   logic [SEC_W-1:0]     on_cnt      [NUM_PUMPS];
   logic [SEC_W-1:0]     on_cnt_nx   [NUM_PUMPS];
   logic [SEC_W-1:0]     period      [NUM_PUMPS];
   logic [SEC_W-1:0]     period_nx   [NUM_PUMPS];
   logic [SEC_W-1:0]     on_time     [NUM_PUMPS];
   logic [SEC_W-1:0]     on_time_nx  [NUM_PUMPS];
   logic [SEC_W-1:0]     shot_len    [NUM_PUMPS];
   logic [SEC_W-1:0]     shot_len_nx [NUM_PUMPS];
   logic [NUM_PUMPS-1:0] periodic;
   logic [NUM_PUMPS-1:0] periodic_nx;

   logic                 chan_ok;
   logic                 cmd_ok;
   logic                 hit;
   logic                 ack_nx;
   logic                 err_nx;
   logic                 ack_r;
   logic                 err_r;

   logic                 busy;
   logic                 found;
   logic [NUM_PUMPS-1:0] grant;

   function automatic logic [SEC_W-1:0] dec_sat(input logic [SEC_W-1:0] v);
      return (v == '0) ? v : v - SEC_W'(1);
   endfunction

   // Prescaler: free-running, shared by every channel, never restarted by commands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (presc == PS_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + PS_W'(1);
      end
   end

   assign sec_tick = (presc == PS_LAST);

   // Command validation; STOP_ALL has no channel so it can never be rejected
   always_comb begin
      chan_ok = (32'(cmd.cmd_chan) < 32'(NUM_PUMPS));
      cmd_ok  = 1'b0;
      case (cmd.cmd_op)
         OP_START:  cmd_ok = chan_ok && (cmd.cmd_period != '0) && (cmd.cmd_on_time != '0);
         OP_STOP:   cmd_ok = chan_ok;
         OP_MANUAL: cmd_ok = chan_ok && (cmd.cmd_on_time != '0);
         default:   cmd_ok = 1'b1;
      endcase
      ack_nx = cmd.cmd_valid && cmd_ok;
      err_nx = cmd.cmd_valid && !cmd_ok;
   end

   // Grant arbitration works on the registered states, so a freed pump is re-granted one edge later
   always_comb begin
      busy  = 1'b0;
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < NUM_PUMPS; i++) begin
         if (state[i] == PULSE) busy = 1'b1;
      end
      for (int i = 0; i < NUM_PUMPS; i++) begin
         if (state[i] == PEND) begin
            if (EXCLUSIVE == 0) begin
               grant[i] = 1'b1;
            end else if (!busy && !found) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      hit         = 1'b0;
      periodic_nx = periodic;
      for (int i = 0; i < NUM_PUMPS; i++) begin
         state_nx[i]    = state[i];
         wait_cnt_nx[i] = wait_cnt[i];
         on_cnt_nx[i]   = on_cnt[i];
         period_nx[i]   = period[i];
         on_time_nx[i]  = on_time[i];
         shot_len_nx[i] = shot_len[i];
         hit            = ack_nx && (cmd.cmd_chan == CH_W'(i));

         case (state[i])
            WAIT: begin
               if (sec_tick) begin
                  wait_cnt_nx[i] = dec_sat(wait_cnt[i]);
                  if (wait_cnt[i] <= SEC_W'(1)) state_nx[i] = PEND;
               end
            end
            PEND: begin
               if (grant[i]) begin
                  state_nx[i]  = PULSE;
                  on_cnt_nx[i] = shot_len[i];
               end
            end
            PULSE: begin
               if (sec_tick) begin
                  on_cnt_nx[i] = dec_sat(on_cnt[i]);
                  if (on_cnt[i] <= SEC_W'(1)) begin
                     // The period restarts from the end of the pulse; a manual shot hands back the scheduled length
                     if (periodic[i]) begin
                        state_nx[i]    = WAIT;
                        wait_cnt_nx[i] = period[i];
                        shot_len_nx[i] = on_time[i];
                     end else begin
                        state_nx[i] = IDLE;
                     end
                  end
               end
            end
            default: ;
         endcase

         // Commands override whatever the counters would have done this cycle
         if (ack_nx && (cmd.cmd_op == OP_STOP_ALL)) begin
            state_nx[i]    = IDLE;
            periodic_nx[i] = 1'b0;
         end else if (hit) begin
            case (cmd.cmd_op)
               OP_START: begin
                  period_nx[i]   = cmd.cmd_period;
                  on_time_nx[i]  = cmd.cmd_on_time;
                  shot_len_nx[i] = cmd.cmd_on_time;
                  periodic_nx[i] = 1'b1;
                  wait_cnt_nx[i] = cmd.cmd_period;
                  on_cnt_nx[i]   = '0;
                  state_nx[i]    = WAIT;
               end
               OP_STOP: begin
                  state_nx[i]    = IDLE;
                  periodic_nx[i] = 1'b0;
               end
               OP_MANUAL: begin
                  if ((state[i] == IDLE) || (state[i] == WAIT)) begin
                     shot_len_nx[i] = cmd.cmd_on_time;
                     state_nx[i]    = PEND;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PUMPS; i++) begin
            state[i]    <= IDLE;
            wait_cnt[i] <= '0;
            on_cnt[i]   <= '0;
            period[i]   <= '0;
            on_time[i]  <= '0;
            shot_len[i] <= '0;
         end
         periodic <= '0;
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PUMPS; i++) begin
            state[i]    <= state_nx[i];
            wait_cnt[i] <= wait_cnt_nx[i];
            on_cnt[i]   <= on_cnt_nx[i];
            period[i]   <= period_nx[i];
            on_time[i]  <= on_time_nx[i];
            shot_len[i] <= shot_len_nx[i];
         end
         periodic <= periodic_nx;
         ack_r    <= ack_nx;
         err_r    <= err_nx;
      end
   end

   assign cmd.cmd_ack = ack_r;
   assign cmd.cmd_err = err_r;

   // Pump drive comes straight from the state register so reset drops it without a clock
   always_comb begin
      pump_out = '0;
      active   = '0;
      for (int i = 0; i < NUM_PUMPS; i++) begin
         pump_out[i] = (state[i] == PULSE);
         active[i]   = (state[i] != IDLE);
      end
   end
endmodule

// File: tb/tb_pump_scheduler.sv
// Bench for pump_scheduler: command responses are queued when a command is driven and
// compared when cmd_ack/cmd_err appear; pump timing is checked scenario by scenario.
module tb_pump_scheduler;
   localparam int N  = 3;
   localparam int CF = 10;
   localparam int SW = 8;

   localparam logic [1:0] OP_START    = 2'd0;
   localparam logic [1:0] OP_STOP     = 2'd1;
   localparam logic [1:0] OP_MANUAL   = 2'd2;
   localparam logic [1:0] OP_STOP_ALL = 2'd3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] pump;
   logic [N-1:0] act;
   logic         tick;
   logic [N-1:0] pump_nx;
   logic [N-1:0] act_nx;
   logic         tick_nx;

   int           checks = 0;
   int           errors = 0;
   int           sent = 0;
   int           resp_seen = 0;
   int           ovl = 0;
   int           ovl_nx = 0;
   logic [1:0]   exp_q[$];

   always #5 clk = ~clk;

   pump_scheduler_if #(.NUM_PUMPS(N), .SEC_W(SW)) bus ();
   pump_scheduler_if #(.NUM_PUMPS(N), .SEC_W(SW)) bus_nx ();

   pump_scheduler #(.NUM_PUMPS(N), .CLOCK_FREQ(CF), .SEC_W(SW), .EXCLUSIVE(1)) dut (
      .clk(clk), .rst(rst), .cmd(bus), .pump_out(pump), .active(act), .sec_tick(tick)
   );

   pump_scheduler #(.NUM_PUMPS(N), .CLOCK_FREQ(CF), .SEC_W(SW), .EXCLUSIVE(0)) dut_nx (
      .clk(clk), .rst(rst), .cmd(bus_nx), .pump_out(pump_nx), .active(act_nx), .sec_tick(tick_nx)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Drives one command on both instances, then pops and compares the response a cycle later
   task automatic send(input logic [1:0] op, input int ch, input int per, input int on, input bit ok);
      logic [1:0] exp_resp;
      @(negedge clk);
      bus.cmd_valid      = 1'b1;
      bus.cmd_op         = op;
      bus.cmd_chan       = 2'(ch);
      bus.cmd_period     = 8'(per);
      bus.cmd_on_time    = 8'(on);
      bus_nx.cmd_valid   = 1'b1;
      bus_nx.cmd_op      = op;
      bus_nx.cmd_chan    = 2'(ch);
      bus_nx.cmd_period  = 8'(per);
      bus_nx.cmd_on_time = 8'(on);
      exp_q.push_back(ok ? 2'b10 : 2'b01);
      sent++;
      @(negedge clk);
      bus.cmd_valid    = 1'b0;
      bus_nx.cmd_valid = 1'b0;
      if (bus.cmd_ack || bus.cmd_err) begin
         exp_resp = exp_q.pop_front();
         check_val("resp", 32'({bus.cmd_ack, bus.cmd_err}), 32'(exp_resp));
         check_val("resp_nx", 32'({bus_nx.cmd_ack, bus_nx.cmd_err}), 32'(exp_resp));
      end else begin
         check_val("resp_missing", 32'(0), 32'(1));
      end
   endtask

   task automatic wait_tick(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!tick && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!tick) check_val("tick_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_pump(input int ch, input logic lvl, input int budget, output int ticks);
      int n;
      n     = 0;
      ticks = 0;
      while (pump[ch] !== lvl && n < budget) begin
         if (tick) ticks++;
         @(negedge clk);
         n++;
      end
      if (pump[ch] !== lvl) check_val("pump_wait_timeout", 32'(0), 32'(1));
   endtask

   task automatic run_len(input int ch, input logic lvl, input int budget, output int n);
      n = 0;
      while (pump[ch] === lvl && n < budget) begin
         n++;
         @(negedge clk);
      end
      if (n >= budget) check_val("run_len_timeout", 32'(0), 32'(1));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cmd_ack || bus.cmd_err) resp_seen++;
         if ($countones(pump) > 1) ovl++;
         if ($countones(pump_nx) > 1) ovl_nx++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int t;
      int ovl0;
      int ovl_nx0;

      bus.cmd_valid      = 1'b0;
      bus.cmd_op         = 2'd0;
      bus.cmd_chan       = 2'd0;
      bus.cmd_period     = 8'd0;
      bus.cmd_on_time    = 8'd0;
      bus_nx.cmd_valid   = 1'b0;
      bus_nx.cmd_op      = 2'd0;
      bus_nx.cmd_chan    = 2'd0;
      bus_nx.cmd_period  = 8'd0;
      bus_nx.cmd_on_time = 8'd0;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_pump", 32'(pump), 32'(0));
      check_val("rst_active", 32'(act), 32'(0));
      check_val("rst_ack", 32'(bus.cmd_ack), 32'(0));
      check_val("rst_err", 32'(bus.cmd_err), 32'(0));
      check_val("rst_tick", 32'(tick), 32'(0));
      rst = 1'b0;
      n = 0;
      while (!tick && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("first_tick", 32'(n), 32'(9));
      check_val("first_tick_nx", 32'(tick_nx), 32'(1));

      // Periodic run: period 2, on 1
      send(OP_START, 0, 2, 1, 1'b1);
      check_val("s1_active", 32'(act), 32'(3'b001));
      wait_pump(0, 1'b1, 100, t);
      check_val("s1_ticks_to_rise", 32'(t), 32'(2));
      run_len(0, 1'b1, 100, n);
      check_val("s1_high", 32'(n), 32'(9));
      run_len(0, 1'b0, 100, n);
      check_val("s1_gap", 32'(n), 32'(21));
      run_len(0, 1'b1, 100, n);
      check_val("s1_high2", 32'(n), 32'(9));
      send(OP_STOP, 0, 0, 0, 1'b1);
      check_val("s1_stopped", 32'(act), 32'(0));

      // Manual shot on an idle channel
      send(OP_MANUAL, 1, 0, 2, 1'b1);
      check_val("s2_pend", 32'({pump, act}), 32'({3'b000, 3'b010}));
      @(negedge clk);
      check_val("s2_rise", 32'(pump), 32'(3'b010));
      run_len(1, 1'b1, 100, n);
      check_val("s2_len_in_range", 32'((n >= 11) && (n <= 20)), 32'(1));
      check_val("s2_idle", 32'(act), 32'(0));

      // Exclusion: two channels requesting in the same tick window
      ovl0    = ovl;
      ovl_nx0 = ovl_nx;
      wait_tick(20);
      send(OP_START, 0, 1, 3, 1'b1);
      send(OP_START, 2, 1, 3, 1'b1);
      wait_pump(0, 1'b1, 100, t);
      check_val("s3_first", 32'(pump), 32'(3'b001));
      run_len(0, 1'b1, 100, n);
      check_val("s3_ch0_len", 32'(n), 32'(29));
      check_val("s3_ch2_waits", 32'(pump), 32'(3'b000));
      @(negedge clk);
      check_val("s3_ch2_rise", 32'(pump), 32'(3'b100));
      run_len(2, 1'b1, 100, n);
      check_val("s3_ch2_len", 32'(n), 32'(29));
      @(negedge clk);
      check_val("s3_ch0_again", 32'(pump), 32'(3'b001));
      check_val("s3_excl_overlap", 32'(ovl - ovl0), 32'(0));
      check_val("s3_nx_overlap", 32'((ovl_nx - ovl_nx0) > 0), 32'(1));
      send(OP_STOP_ALL, 3, 0, 0, 1'b1);
      check_val("s3_stop_all", 32'(act), 32'(0));
      check_val("s3_stop_all_nx", 32'(act_nx), 32'(0));

      // Rejected commands leave the running schedule untouched
      send(OP_START, 0, 5, 1, 1'b1);
      send(OP_START, 3, 2, 1, 1'b0);
      check_val("s4_bad_chan", 32'(act), 32'(3'b001));
      send(OP_START, 1, 0, 2, 1'b0);
      check_val("s4_zero_period", 32'(act), 32'(3'b001));
      send(OP_START, 1, 2, 0, 1'b0);
      send(OP_MANUAL, 1, 0, 0, 1'b0);
      check_val("s4_zero_manual", 32'({pump, act}), 32'({3'b000, 3'b001}));
      send(OP_MANUAL, 3, 0, 1, 1'b0);
      send(OP_STOP, 3, 0, 0, 1'b0);
      check_val("s4_unchanged", 32'(act), 32'(3'b001));
      send(OP_STOP_ALL, 0, 0, 0, 1'b1);
      check_val("s4_cleared", 32'(act), 32'(0));

      // STOP mid-pulse hands the pump to a pending channel one edge later
      wait_tick(20);
      send(OP_START, 0, 1, 3, 1'b1);
      wait_pump(0, 1'b1, 100, t);
      send(OP_MANUAL, 1, 0, 1, 1'b1);
      check_val("s5_pend", 32'({pump, act}), 32'({3'b001, 3'b011}));
      send(OP_STOP, 0, 0, 0, 1'b1);
      check_val("s5_stop_fall", 32'(pump), 32'(3'b000));
      @(negedge clk);
      check_val("s5_ch1_rise", 32'(pump), 32'(3'b010));

      // Asynchronous reset mid-pulse
      #3 rst = 1'b1;
      #1;
      check_val("s6_async_pump", 32'(pump), 32'(0));
      check_val("s6_async_active", 32'(act), 32'(0));
      check_val("s6_async_pump_nx", 32'(pump_nx), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("s6_idle", 32'({pump, act}), 32'(0));
      n = 0;
      while (!tick && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("s6_presc_restart", 32'(n), 32'(9));
      repeat (2) @(negedge clk);

      check_val("sb_drain", 32'(exp_q.size()), 32'(0));
      check_val("resp_count", 32'(resp_seen), 32'(sent));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pump_scheduler.md
# pump_scheduler

Parametrised N-channel fragrance-pump scheduler. It replaces the fixed three-pump controller with a command-driven block that carries a per-channel period and on-time, a periodic or one-shot mode, manual pulses that do not disturb the schedule, and optional mutual exclusion so only one pump draws current at a time. It sits between the UI/command decoder and the pump driver pins, and shares one seconds prescaler across all channels.

## Interface
- NUM_PUMPS, 3: channel count, 1..16.
- CLOCK_FREQ, 1_000_000: clk cycles per second tick, ≥2.
- SEC_W, 16: width of period and on-time fields, in seconds.
- EXCLUSIVE, 1: 1 allows at most one pump on at a time; 0 lets pumps run independently.
- CH_W: derived as max(1, clog2(NUM_PUMPS)); not overridable.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  one-cycle command strobe; always accepted.
- cmd_op  in  2  0=START, 1=STOP, 2=MANUAL, 3=STOP_ALL.
- cmd_chan  in  CH_W  target channel (ignored for STOP_ALL).
- cmd_period  in  SEC_W  seconds between pulses (START only).
- cmd_on_time  in  SEC_W  pulse length in seconds (START and MANUAL).
- cmd_ack  out  1  one-cycle pulse, the cycle after an accepted command.
- cmd_err  out  1  one-cycle pulse, the cycle after a rejected command.
- pump_out  out  NUM_PUMPS  pump drive, high while the channel is in PULSE.
- active  out  NUM_PUMPS  high while the channel is not IDLE.
- sec_tick  out  1  one-cycle pulse, once per second.

## Operation
- Prescaler:
  - Free-running counter 0..CLOCK_FREQ-1.
  - sec_tick is high in the cycle the counter equals CLOCK_FREQ-1.
  - It is never restarted by commands.
- Per-channel registers: state, wait_cnt, on_cnt, period, on_time, periodic flag.
- States:
  - IDLE: pump off.
  - WAIT: counting down the period.
  - PEND: pulse requested, waiting for grant.
  - PULSE: pump on.
- START (period≠0, on_time≠0, chan<NUM_PUMPS), from any state:
  - Latch period and on_time; set periodic=1.
  - wait_cnt←period; state←WAIT.
  - If the channel was in PULSE, the pulse ends immediately.
- STOP: state←IDLE; periodic←0.
- STOP_ALL: every channel goes to IDLE.
- MANUAL (on_time≠0):
  - Loads on_time into a one-shot length.
  - From IDLE or WAIT: state←PEND. Periodic channels keep their schedule and return to WAIT with wait_cnt←period after the pulse.
  - From PEND or PULSE: acked, no effect.
- Rejection → cmd_err, no state change:
  - chan ≥ NUM_PUMPS;
  - START with period=0 or on_time=0;
  - MANUAL with on_time=0.
- WAIT: on sec_tick, wait_cnt decrements. When it reaches 0, state←PEND.
- PEND→PULSE, with on_cnt←pulse length:
  - EXCLUSIVE=0: next cycle.
  - EXCLUSIVE=1: only when no channel is in PULSE. The lowest-index PEND channel wins; the others stay in PEND. At most one grant per cycle.
- PULSE: on sec_tick, on_cnt decrements. At 0:
  - periodic: WAIT with wait_cnt←period (period measured from pulse end);
  - otherwise: IDLE.
- Arithmetic:
  - Counters are SEC_W bits and unsigned.
  - Decrement only when nonzero; no wrap.
  - Max period 2^SEC_W−1 s.

## Timing
- Reset values: all channels IDLE, all counters 0, pump_out=0, active=0, cmd_ack=0, cmd_err=0, sec_tick=0, prescaler=0.
- Reset may assert at any cycle, including mid-pulse. pump_out drops asynchronously and no pending request survives.
- Outputs:
  - pump_out and active are decoded from the state register: no combinational path from cmd_* inputs.
  - cmd_ack and cmd_err are registered.
- Command sampled at edge k takes effect in the state after edge k. MANUAL on a free channel:
  - PEND after edge k;
  - PULSE and pump_out=1 after edge k+1.
- Simultaneous events on one channel in one cycle: a command overrides the tick/counter transition.
- A STOP or START that hits a channel in PULSE frees the exclusion in the same cycle. Another PEND channel may be granted at the next edge.
- Pulse length is (on_time−1)·CLOCK_FREQ+1 to on_time·CLOCK_FREQ cycles, because the prescaler phase is shared.
- WAIT length has the same bounds, with period in place of on_time.

## Test plan
All scenarios use CLOCK_FREQ=10, NUM_PUMPS=3, SEC_W=8, EXCLUSIVE=1 unless stated.
- Reset and periodic run: release rst, START ch0 period=2 on=1.
  - cmd_ack one cycle later; active[0]=1.
  - pump_out[0] rises after 2 ticks, stays high for 1 tick.
  - Rises again 2 ticks after falling; repeats.
- Manual on idle: MANUAL ch1 on=2.
  - pump_out[1]=1 two cycles after the strobe, for 11..20 cycles.
  - Then active[1]=0.
- Exclusion: START ch0 and ch2 with period=1 on=3, issued in the same tick window.
  - Never more than one pump_out bit high.
  - ch0 is served first; ch2 rises the cycle after ch0 falls.
  - Repeat with EXCLUSIVE=0: both bits high together.
- Errors: START ch3, START period=0, MANUAL on=0.
  - cmd_err pulses each time; state unchanged; no cmd_ack.
- STOP mid-pulse and STOP_ALL:
  - STOP ch0 while pump_out[0]=1: the bit falls after the next edge, and a PEND ch1 rises one edge later.
  - STOP_ALL: every active bit clears.
- Async reset mid-pulse: assert rst between edges while pump_out[1]=1.
  - pump_out clears without waiting for clk.
  - After release, all channels are IDLE and the prescaler restarts from 0.
